// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, default sizing and the address-error rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEPTH_WORDS_DEFAULT = 64;
  localparam int LATENCY_MAX         = 7;
  localparam int CNT_W               = 3;

  // Misaligned, or word index past the end; compared at the full 30-bit width so nothing wraps.
  function automatic logic addr_err(input logic [31:0] addr, input logic [29:0] depth_words);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: synchronous write, combinational read.
// Contents are deliberately never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Storage write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a fixed programmable response latency.
// Stores commit at acceptance; loads sample storage on the edge entering RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i32,
  input  logic [31:0] req_wdata_i32,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o32,
  output logic        rsp_err_o
);

  localparam int              AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0]     DEPTH_W30 = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? {CNT_W{1'b0}} : CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             perr_q, perr_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rerr_q, rerr_d;

  logic             req_err_s;
  logic [AW-1:0]    req_idx_s;
  logic             wr_en_s;
  logic [AW-1:0]    rd_idx_s;
  logic [31:0]      rd_data_s;
  logic             enter_resp_s;
  logic             cur_we_s;
  logic             cur_err_s;

  assign req_err_s = addr_err(req_addr_i32, DEPTH_W30);
  assign req_idx_s = req_addr_i32[AW+1:2];

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (wr_en_s),
    .waddr_i(req_idx_s),
    .wdata_i(req_wdata_i32),
    .raddr_i(rd_idx_s),
    .rdata_o(rd_data_s)
  );

  // Next-state, capture and response-register logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    perr_d       = perr_q;
    idx_d        = idx_q;
    rdata_d      = rdata_q;
    rerr_d       = rerr_q;
    wr_en_s      = 1'b0;
    enter_resp_s = 1'b0;
    rd_idx_s     = idx_q;
    cur_we_s     = we_q;
    cur_err_s    = perr_q;

    case (state_q)
      IDLE: begin
        // With zero latency the response is built from the live request on the accept edge.
        rd_idx_s  = req_idx_s;
        cur_we_s  = req_we_i;
        cur_err_s = req_err_s;
        if (req_valid_i) begin
          we_d    = req_we_i;
          perr_d  = req_err_s;
          idx_d   = req_idx_s;
          wr_en_s = req_we_i & ~req_err_s;
          if (LATENCY == 0) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          rdata_d = 32'h0000_0000;
          rerr_d  = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    if (enter_resp_s) begin
      rerr_d  = cur_err_s;
      rdata_d = (cur_we_s | cur_err_s) ? 32'h0000_0000 : rd_data_s;
    end else begin
      rerr_d  = rerr_d;
      rdata_d = rdata_d;
    end
  end

  // Control and response registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      we_q    <= 1'b0;
      perr_q  <= 1'b0;
      idx_q   <= {AW{1'b0}};
      rdata_q <= 32'h0000_0000;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      perr_q  <= perr_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o32 = rdata_q;
  assign rsp_err_o     = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 1 uses LATENCY=2, instance 0 uses LATENCY=0.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int checks;
  int failures;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i32(req_addr[0]), .req_wdata_i32(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o32(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i32(req_addr[1]), .req_wdata_i32(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o32(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction; returns cycles from acceptance to rsp_valid, response data and handshake sanity.
  task automatic do_req(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err, output logic rdy_ok);
    logic pre_ready;
    pre_ready      = req_ready[sel];
    req_valid[sel] = 1'b1;
    req_we[sel]    = we;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    lat = 0;
    while (rsp_valid[sel] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata[sel];
    err   = rsp_err[sel];
    rsp_ready[sel] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[sel] = 1'b0;
    rdy_ok = pre_ready & ~rsp_valid[sel] & req_ready[sel];
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (rsp_valid[s] !== 1'b0 || rsp_rdata[s] !== 32'h0 || rsp_err[s] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: valid=%b rdata=%h err=%b expected 0/0/0", s, rsp_valid[s], rsp_rdata[s], rsp_err[s]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready dut%0d: got %b expected 1", s, req_ready[s]);
      end
    end
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd; logic er; logic ok;
    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || ok !== 1'b1) begin
      failures++;
      $display("FAIL store_0x10: lat=%0d err=%b rdata=%h ok=%b expected 2/0/0/1", lat, er, rd, ok);
    end
    do_req(1, 1'b0, 32'h10, 32'h0, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || ok !== 1'b1) begin
      failures++;
      $display("FAIL load_0x10: lat=%0d err=%b rdata=%h ok=%b expected 2/0/deadbeef/1", lat, er, rd, ok);
    end
  endtask

  task automatic test_lat0;
    int lat; logic [31:0] rd; logic er; logic ok;
    do_req(0, 1'b1, 32'h04, 32'h12345678, lat, rd, er, ok);
    checks++;
    if (lat !== 0 || er !== 1'b0 || rd !== 32'h0 || ok !== 1'b1) begin
      failures++;
      $display("FAIL lat0_store: lat=%0d err=%b rdata=%h ok=%b expected 0/0/0/1", lat, er, rd, ok);
    end
    do_req(0, 1'b0, 32'h04, 32'h0, lat, rd, er, ok);
    checks++;
    if (lat !== 0 || er !== 1'b0 || rd !== 32'h12345678) begin
      failures++;
      $display("FAIL lat0_load: lat=%0d err=%b rdata=%h expected 0/0/12345678", lat, er, rd);
    end
    do_req(0, 1'b0, 32'h100, 32'h0, lat, rd, er, ok);
    checks++;
    if (lat !== 0 || er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL lat0_err_load: lat=%0d err=%b rdata=%h expected 0/1/0", lat, er, rd);
    end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd; logic er; logic ok;
    do_req(1, 1'b1, 32'h20, 32'h11112222, lat, rd, er, ok);
    do_req(1, 1'b1, 32'hFC, 32'h33334444, lat, rd, er, ok);
    do_req(1, 1'b1, 32'h00, 32'h0BADF00D, lat, rd, er, ok);
    do_req(1, 1'b1, 32'h22, 32'hFFFFFFFF, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL misaligned_store: lat=%0d err=%b rdata=%h expected 2/1/0", lat, er, rd);
    end
    do_req(1, 1'b1, 32'h100, 32'hFFFFFFFF, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL range_store: lat=%0d err=%b rdata=%h expected 2/1/0", lat, er, rd);
    end
    do_req(1, 1'b0, 32'h80000010, 32'h0, lat, rd, er, ok);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL high_addr_load: err=%b rdata=%h expected 1/0", er, rd);
    end
    do_req(1, 1'b0, 32'h20, 32'h0, lat, rd, er, ok);
    checks++;
    if (er !== 1'b0 || rd !== 32'h11112222) begin
      failures++;
      $display("FAIL load_0x20: err=%b rdata=%h expected 0/11112222", er, rd);
    end
    do_req(1, 1'b0, 32'hFC, 32'h0, lat, rd, er, ok);
    checks++;
    if (er !== 1'b0 || rd !== 32'h33334444) begin
      failures++;
      $display("FAIL load_0xFC: err=%b rdata=%h expected 0/33334444", er, rd);
    end
    do_req(1, 1'b0, 32'h00, 32'h0, lat, rd, er, ok);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL load_0x00: err=%b rdata=%h expected 0/0badf00d", er, rd);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] rd; logic er; logic ok;
    int n;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h10;
    req_wdata[1] = 32'h0;
    @(posedge clk); #1;
    // Keep a competing store presented; it must never be taken.
    req_we[1] = 1'b1;
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL bp_latency: got %0d expected 2", n);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hDEADBEEF || rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h err=%b ready=%b expected 1/deadbeef/0/0", i, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1]);
      end
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0/1", rsp_valid[1], req_ready[1]);
    end
    do_req(1, 1'b0, 32'h10, 32'h0, lat, rd, er, ok);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_accept: rdata=%h err=%b expected deadbeef/0", rd, er);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er; logic ok;
    logic seen;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h08;
    req_wdata[1] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | rsp_valid[1];
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen = seen | rsp_valid[1];
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0 || req_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_drop: valid_seen=%b ready=%b expected 0/1", seen, req_ready[1]);
    end
    do_req(1, 1'b0, 32'h08, 32'h0, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_commit: lat=%0d rdata=%h err=%b expected 2/a5a5a5a5/0", lat, rd, er);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b00;
    for (int s = 0; s < 2; s++) begin
      req_addr[s]  = 32'h0;
      req_wdata[s] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_lat0();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, storage depth in 32-bit words, power of two, range 4..1024.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles inserted before each response, range 0..7.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports are named clk_i and reset_ni.
REQ-004 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_ni  input  1  asynchronous active-low reset.
REQ-006 req_valid_i  input  1  the core presents a load/store request.
REQ-007 req_ready_o  output  1  the responder can accept a request this cycle.
REQ-008 req_we_i  input  1  1 = store, 0 = load.
REQ-009 req_addr_i32  input  32  byte address (the core's ALU result).
REQ-010 req_wdata_i32  input  32  store data.
REQ-011 rsp_valid_o  output  1  response available.
REQ-012 rsp_ready_i  input  1  the core consumes the response.
REQ-013 rsp_rdata_o32  output  32  load data; 0 for stores and for errored requests.
REQ-014 rsp_err_o  output  1  the request was misaligned or out of range.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 req_ready_o SHALL be 1 only in IDLE; the block holds one outstanding transaction at most.
REQ-017 Acceptance SHALL occur when req_valid_i & req_ready_o is high at a rising edge; address, we and wdata are captured at that edge.
REQ-018 On acceptance the FSM SHALL go to WAIT with the wait counter loaded with LATENCY-1; if LATENCY=0 it SHALL go directly to RESP.
REQ-019 In WAIT the counter SHALL decrement each cycle; when it reaches 0 the FSM SHALL go to RESP on the next edge.
REQ-020 Response timing: for a request accepted in cycle t, rsp_valid_o SHALL first be 1 in cycle t+1+LATENCY.
REQ-021 In RESP, rsp_valid_o, rsp_rdata_o32 and rsp_err_o SHALL be held stable until rsp_ready_i=1; on that edge the FSM SHALL return to IDLE.
REQ-022 Request acceptance in the handshake cycle SHALL not be possible, because req_ready_o stays 0 in RESP.
REQ-023 A request SHALL be errored if req_addr_i32[1:0]!=0, or if the word index req_addr_i32[31:2] is >= DEPTH_WORDS.
REQ-024 A valid store SHALL write storage at the acceptance edge; an errored store SHALL not write.
REQ-025 A load SHALL sample storage on the edge entering RESP into an output register, so a load that follows a store returns the new data.
REQ-026 For an errored request, rsp_rdata_o32 SHALL be 0 and rsp_err_o SHALL be 1; otherwise rsp_err_o SHALL be 0.
REQ-027 No arithmetic wrap SHALL occur: indices are compared at the full 30-bit width, never truncated.

Reset
REQ-028 While reset_ni=0 the block SHALL be in IDLE with: req_ready_o=1 after release, rsp_valid_o=0, rsp_rdata_o32=0, rsp_err_o=0, counter=0.
REQ-029 A reset asserted mid-transaction SHALL drop any pending response; a store already committed at acceptance SHALL remain committed.
REQ-030 Storage contents SHALL not be reset.

Structure
REQ-031 Package dmem_pkg SHALL hold the state enum (IDLE, WAIT, RESP), DEPTH_WORDS_DEFAULT, LATENCY_MAX=7 and the counter width (3).
REQ-032 Sub-module dmem_array SHALL hold the storage: synchronous write, combinational read, parameterised by DEPTH_WORDS.

Verification
REQ-033 LATENCY=2: store 0xDEADBEEF to 0x10, then load from 0x10 -> store response err=0 at t+3; load rdata=0xDEADBEEF at acceptance+3.
REQ-034 LATENCY=0: load from 0x04 after a store of 0x12345678 -> rsp_valid_o=1 in the cycle after acceptance, rdata=0x12345678.
REQ-035 Store to 0x22 (misaligned) and store to 0x100 with DEPTH=64 -> err=1, rdata=0; a subsequent load from word 8 (0x20) and from 0xFC returns the prior contents unchanged.
REQ-036 Backpressure: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and data stable and req_ready_o=0 throughout; a new req_valid_i is not accepted.
REQ-037 Reset in WAIT after a store of 0xA5A5A5A5 to 0x08 -> rsp_valid_o never rises; after reset, a load from 0x08 returns 0xA5A5A5A5.
